// File: rtl/wb_regfile_pkg.sv
// Shared constants, bus types and the scoreboard update helper for the
// write-back register file slice.
package wb_regfile_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int SB_CNT_W   = 2;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [DATA_W-1:0]     ZERO_WORD    = 32'h0000_0000;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'd0;
  localparam logic [SB_CNT_W-1:0]   SB_CNT_MAX   = 2'd3;
  localparam logic [SB_CNT_W-1:0]   SB_CNT_ZERO  = 2'd0;
  localparam logic [SB_CNT_W-1:0]   SB_CNT_ONE   = 2'd1;

  typedef logic [DATA_W-1:0]     reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [SB_CNT_W-1:0]   sb_cnt_t;

  typedef enum logic [1:0] {
    SB_HOLD = 2'd0,
    SB_INC  = 2'd1,
    SB_DEC  = 2'd2,
    SB_CLR  = 2'd3
  } sb_op_e;

  // Flush dominates; simultaneous issue and retire cancel out.
  function automatic sb_op_e sb_op(input logic flush, input logic inc, input logic dec);
    sb_op_e op;
    if (flush) begin
      op = SB_CLR;
    end else if (inc && !dec) begin
      op = SB_INC;
    end else if (dec && !inc) begin
      op = SB_DEC;
    end else begin
      op = SB_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register in-flight write counters: ID issue increments, WB retire
// decrements, flush clears; drives the operand stall requests and sb_err.
module wb_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_iss_valid,
  input  logic      i_iss_wreg,
  input  reg_addr_t i_iss_wd,
  input  logic      i_wb_wreg,
  input  reg_addr_t i_wb_wd,
  input  logic      i_flush,
  input  logic      i_re1,
  input  reg_addr_t i_raddr1,
  input  logic      i_re2,
  input  reg_addr_t i_raddr2,
  output logic      o_busy1,
  output logic      o_busy2,
  output logic      o_sb_err
);

  logic [REG_NUM-1:0][SB_CNT_W-1:0] r_cnt;
  logic [REG_NUM-1:0][SB_CNT_W-1:0] w_cnt_nxt;
  logic [REG_NUM-1:0]               w_inc;
  logic [REG_NUM-1:0]               w_dec;
  logic                             w_err_set;
  logic                             r_sb_err;

  // Per-register issue/retire decode; x0 never takes part.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      w_inc[r] = i_iss_valid && i_iss_wreg && (i_iss_wd == reg_addr_t'(r));
      w_dec[r] = (i_wb_wreg == WRITE_ENABLE) && (i_wb_wd == reg_addr_t'(r));
    end
  end

  // Saturating counter update and overflow/underflow detection.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    for (int r = 1; r < REG_NUM; r++) begin
      case (sb_op(i_flush, w_inc[r], w_dec[r]))
        SB_CLR: w_cnt_nxt[r] = SB_CNT_ZERO;
        SB_INC: begin
          if (r_cnt[r] == SB_CNT_MAX) begin
            w_err_set = 1'b1;
          end else begin
            w_cnt_nxt[r] = r_cnt[r] + SB_CNT_ONE;
          end
        end
        SB_DEC: begin
          if (r_cnt[r] == SB_CNT_ZERO) begin
            w_err_set = 1'b1;
          end else begin
            w_cnt_nxt[r] = r_cnt[r] - SB_CNT_ONE;
          end
        end
        SB_HOLD: w_cnt_nxt[r] = r_cnt[r];
        default: w_cnt_nxt[r] = r_cnt[r];
      endcase
    end
  end

  // Counter state and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) begin
      r_cnt    <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_err_set) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  // A sole writer retiring this cycle is not a hazard: its data is bypassed.
  always_comb begin
    o_busy1 = 1'b0;
    o_busy2 = 1'b0;
    if (i_rst == RST_ENABLE) begin
      o_busy1 = 1'b0;
      o_busy2 = 1'b0;
    end else begin
      o_busy1 = i_re1 && (i_raddr1 != NOP_REG_ADDR) && (r_cnt[i_raddr1] != SB_CNT_ZERO)
                && !((r_cnt[i_raddr1] == SB_CNT_ONE) && w_dec[i_raddr1]);
      o_busy2 = i_re2 && (i_raddr2 != NOP_REG_ADDR) && (r_cnt[i_raddr2] != SB_CNT_ZERO)
                && !((r_cnt[i_raddr2] == SB_CNT_ONE) && w_dec[i_raddr2]);
    end
  end

  assign o_sb_err = r_sb_err;

endmodule

// File: rtl/wb_regfile.sv
// 32x32 GPR file with two bypassed read ports and an in-flight write scoreboard.
// Optional debug read port and retire counter under REGFILE_DEBUG_EN.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_wb_wreg,
  input  reg_addr_t i_wb_wd,
  input  reg_bus_t  i_wb_wdata,
  input  logic      i_re1,
  input  reg_addr_t i_raddr1,
  input  logic      i_re2,
  input  reg_addr_t i_raddr2,
  output reg_bus_t  o_rdata1,
  output reg_bus_t  o_rdata2,
  output logic      o_busy1,
  output logic      o_busy2,
  input  logic      i_iss_valid,
  input  logic      i_iss_wreg,
  input  reg_addr_t i_iss_wd,
  input  logic      i_flush,
  output logic      o_sb_err
`ifdef REGFILE_DEBUG_EN
  ,
  input  reg_addr_t i_dbg_raddr,
  output reg_bus_t  o_dbg_rdata,
  output logic [31:0] o_dbg_wb_cnt
`endif
);

  logic [REG_NUM-1:0][DATA_W-1:0] r_regs;
  logic                           w_wr_en;

  function automatic reg_bus_t read_port(
    input logic      rst,
    input logic      re,
    input reg_addr_t raddr,
    input logic      wr_hit,
    input reg_bus_t  wdata,
    input reg_bus_t  stored
  );
    reg_bus_t data;
    if (rst == RST_ENABLE || !re || raddr == NOP_REG_ADDR) begin
      data = ZERO_WORD;
    end else if (wr_hit) begin
      data = wdata;
    end else begin
      data = stored;
    end
    return data;
  endfunction

  assign w_wr_en = (i_wb_wreg == WRITE_ENABLE) && (i_wb_wd != NOP_REG_ADDR);

  // Register array; x0 is never written so it stays zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) begin
      r_regs <= '0;
    end else if (w_wr_en) begin
      r_regs[i_wb_wd] <= i_wb_wdata;
    end
  end

  // Zero-latency read ports with same-cycle write-through.
  always_comb begin
    o_rdata1 = ZERO_WORD;
    o_rdata2 = ZERO_WORD;
    o_rdata1 = read_port(i_rst, i_re1, i_raddr1,
                         (i_wb_wreg == WRITE_ENABLE) && (i_wb_wd == i_raddr1),
                         i_wb_wdata, r_regs[i_raddr1]);
    o_rdata2 = read_port(i_rst, i_re2, i_raddr2,
                         (i_wb_wreg == WRITE_ENABLE) && (i_wb_wd == i_raddr2),
                         i_wb_wdata, r_regs[i_raddr2]);
  end

  wb_scoreboard u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_iss_valid (i_iss_valid),
    .i_iss_wreg  (i_iss_wreg),
    .i_iss_wd    (i_iss_wd),
    .i_wb_wreg   (i_wb_wreg),
    .i_wb_wd     (i_wb_wd),
    .i_flush     (i_flush),
    .i_re1       (i_re1),
    .i_raddr1    (i_raddr1),
    .i_re2       (i_re2),
    .i_raddr2    (i_raddr2),
    .o_busy1     (o_busy1),
    .o_busy2     (o_busy2),
    .o_sb_err    (o_sb_err)
  );

`ifdef REGFILE_DEBUG_EN
  logic [31:0] r_dbg_wb_cnt;

  // Retired non-x0 write counter, free-running modulo 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) begin
      r_dbg_wb_cnt <= 32'd0;
    end else if (w_wr_en) begin
      r_dbg_wb_cnt <= r_dbg_wb_cnt + 32'd1;
    end
  end

  // Raw array view, deliberately without the WB bypass.
  always_comb begin
    o_dbg_rdata = ZERO_WORD;
    if (i_dbg_raddr == NOP_REG_ADDR) begin
      o_dbg_rdata = ZERO_WORD;
    end else begin
      o_dbg_rdata = r_regs[i_dbg_raddr];
    end
  end

  assign o_dbg_wb_cnt = r_dbg_wb_cnt;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default build, debug port off).
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      wb_wreg;
  reg_addr_t wb_wd;
  reg_bus_t  wb_wdata;
  logic      re1, re2;
  reg_addr_t raddr1, raddr2;
  reg_bus_t  rdata1, rdata2;
  logic      busy1, busy2;
  logic      iss_valid, iss_wreg;
  reg_addr_t iss_wd;
  logic      flush;
  logic      sb_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_wreg   (wb_wreg),
    .i_wb_wd     (wb_wd),
    .i_wb_wdata  (wb_wdata),
    .i_re1       (re1),
    .i_raddr1    (raddr1),
    .i_re2       (re2),
    .i_raddr2    (raddr2),
    .o_rdata1    (rdata1),
    .o_rdata2    (rdata2),
    .o_busy1     (busy1),
    .o_busy2     (busy2),
    .i_iss_valid (iss_valid),
    .i_iss_wreg  (iss_wreg),
    .i_iss_wd    (iss_wd),
    .i_flush     (flush),
    .o_sb_err    (sb_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    iss_valid = 1'b0; iss_wreg = 1'b0; iss_wd = 5'd0; flush = 1'b0;
  endtask

  task automatic issue(input reg_addr_t rd);
    iss_valid = 1'b1; iss_wreg = 1'b1; iss_wd = rd;
  endtask

  task automatic retire(input reg_addr_t rd, input reg_bus_t data);
    wb_wreg = 1'b1; wb_wd = rd; wb_wdata = data;
  endtask

  task automatic read1(input reg_addr_t a);
    re1 = 1'b1; raddr1 = a;
  endtask

  task automatic read2(input reg_addr_t a);
    re2 = 1'b1; raddr2 = a;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step(); step();
    read1(5'd4); settle();
    check_eq("rst_rdata1", rdata1, 32'h0);
    check_eq("rst_busy1", {31'd0, busy1}, 32'd0);
    rst = 1'b0;
    clear_inputs(); step();

    // all GPRs read zero after reset
    for (int a = 1; a < 32; a++) begin
      read1(reg_addr_t'(a)); read2(reg_addr_t'(32 - a)); settle();
      check_eq($sformatf("reset_x%0d", a), rdata1, 32'h0);
      check_eq($sformatf("reset_p2_x%0d", 32 - a), rdata2, 32'h0);
      step();
    end
    check_eq("reset_sb_err", {31'd0, sb_err}, 32'd0);

    // x0 is hardwired: neither bypass nor store applies
    clear_inputs(); retire(5'd0, 32'hDEADBEEF); read1(5'd0); settle();
    check_eq("x0_bypass", rdata1, 32'h0);
    step(); clear_inputs(); read1(5'd0); settle();
    check_eq("x0_stored", rdata1, 32'h0);
    check_eq("x0_no_err", {31'd0, sb_err}, 32'd0);

    // issue x5, then WB x5 with same-cycle read on both ports
    clear_inputs(); issue(5'd5); step();
    clear_inputs(); read1(5'd5); settle();
    check_eq("x5_busy_before_wb", {31'd0, busy1}, 32'd1);
    retire(5'd5, 32'h12345678); read2(5'd5); settle();
    check_eq("x5_bypass_p1", rdata1, 32'h12345678);
    check_eq("x5_bypass_p2", rdata2, 32'h12345678);
    check_eq("x5_busy_in_wb", {31'd0, busy1}, 32'd0);
    step(); clear_inputs(); read1(5'd5); settle();
    check_eq("x5_stored", rdata1, 32'h12345678);
    check_eq("x5_re_off", rdata2, 32'h0);

    // single writer x7
    clear_inputs(); issue(5'd7); step();
    clear_inputs(); read1(5'd7); settle();
    check_eq("x7_busy", {31'd0, busy1}, 32'd1);
    re1 = 1'b0; settle();
    check_eq("x7_busy_re_off", {31'd0, busy1}, 32'd0);
    step();
    read1(5'd7); retire(5'd7, 32'h0000_0077); settle();
    check_eq("x7_busy_wb", {31'd0, busy1}, 32'd0);
    check_eq("x7_bypass", rdata1, 32'h0000_0077);
    step(); clear_inputs(); read1(5'd7); settle();
    check_eq("x7_cnt_zero", {31'd0, busy1}, 32'd0);
    check_eq("x7_stored", rdata1, 32'h0000_0077);

    // two writers to x3
    clear_inputs(); issue(5'd3); step(); step();
    clear_inputs(); read2(5'd3); settle();
    check_eq("x3_busy_cnt2", {31'd0, busy2}, 32'd1);
    retire(5'd3, 32'h33); settle();
    check_eq("x3_busy_first_wb", {31'd0, busy2}, 32'd1);
    step(); clear_inputs(); read2(5'd3); settle();
    check_eq("x3_busy_cnt1", {31'd0, busy2}, 32'd1);
    retire(5'd3, 32'h333); settle();
    check_eq("x3_busy_last_wb", {31'd0, busy2}, 32'd0);
    step(); clear_inputs(); read2(5'd3); settle();
    check_eq("x3_busy_cnt0", {31'd0, busy2}, 32'd0);
    check_eq("x3_sb_err", {31'd0, sb_err}, 32'd0);

    // x9: simultaneous issue+retire holds the count, then saturation
    clear_inputs(); issue(5'd9); step();
    retire(5'd9, 32'h99); step();
    clear_inputs(); read1(5'd9); settle();
    check_eq("x9_busy_hold", {31'd0, busy1}, 32'd1);
    check_eq("x9_no_err_hold", {31'd0, sb_err}, 32'd0);
    issue(5'd9); step(); step();
    clear_inputs(); read1(5'd9); settle();
    check_eq("x9_no_err_cnt3", {31'd0, sb_err}, 32'd0);
    issue(5'd9); step();
    clear_inputs(); read1(5'd9); settle();
    check_eq("x9_overflow_err", {31'd0, sb_err}, 32'd1);
    check_eq("x9_busy_sat", {31'd0, busy1}, 32'd1);
    step(); step(); settle();
    check_eq("x9_err_sticky", {31'd0, sb_err}, 32'd1);

    // flush with x4 in flight and WB writing x4; issue in flush cycle ignored
    clear_inputs(); issue(5'd4); step(); step();
    clear_inputs(); flush = 1'b1; retire(5'd4, 32'h0000_00A5); issue(5'd4); step();
    clear_inputs(); read1(5'd4); read2(5'd9); settle();
    check_eq("flush_busy_x4", {31'd0, busy1}, 32'd0);
    check_eq("flush_busy_x9", {31'd0, busy2}, 32'd0);
    check_eq("flush_reg4", rdata1, 32'h0000_00A5);

    // reset mid-flight
    clear_inputs(); issue(5'd4); step();
    clear_inputs(); rst = 1'b1; read1(5'd4); settle();
    check_eq("rst_mid_busy", {31'd0, busy1}, 32'd0);
    check_eq("rst_mid_rdata", rdata1, 32'h0);
    step(); rst = 1'b0; settle();
    check_eq("post_rst_reg4", rdata1, 32'h0);
    check_eq("post_rst_busy4", {31'd0, busy1}, 32'd0);
    check_eq("post_rst_sb_err", {31'd0, sb_err}, 32'd0);
    read2(5'd5); settle();
    check_eq("post_rst_reg5", rdata2, 32'h0);

    // retire with nothing in flight: underflow, but data still stored
    clear_inputs(); retire(5'd6, 32'hCAFE_F00D); step();
    clear_inputs(); read1(5'd6); settle();
    check_eq("underflow_err", {31'd0, sb_err}, 32'd1);
    check_eq("underflow_busy", {31'd0, busy1}, 32'd0);
    check_eq("underflow_data", rdata1, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
